// File: rtl/conv_output_writer_pkg.sv
// Shared types and defaults for the convolution output writeback stage.
// Header build option: CONV_OUTPUT_WRITER_HEADER_EN.
package conv_output_writer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;
  localparam int COL_W_DEF  = 4;

  localparam logic POS_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HDR
  } state_t;

endpackage

// File: rtl/conv_output_writer_if.sv
// Pixel-decision stream in, SRAM row-write bus and status out.
// master drives pixels/control, slave is the writer.
interface conv_output_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int COL_W  = 4
);
  logic              mat_start;
  logic [ADDR_W-1:0] base_addr;
  logic              pix_valid;
  logic              pix_neg;
  logic [COL_W-1:0]  pix_col;
  logic              row_last;
  logic              mat_last;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [DATA_W-1:0] dut_sram_write_data;
  logic              dut_sram_write_enable;
  logic              mat_done;
  logic              busy;
  logic              err_overrun;

  modport master (
    output mat_start, base_addr, pix_valid, pix_neg,
    output pix_col, row_last, mat_last,
    input  dut_sram_write_address, dut_sram_write_data,
    input  dut_sram_write_enable, mat_done, busy, err_overrun
  );

  modport slave (
    input  mat_start, base_addr, pix_valid, pix_neg,
    input  pix_col, row_last, mat_last,
    output dut_sram_write_address, dut_sram_write_data,
    output dut_sram_write_enable, mat_done, busy, err_overrun
  );
endinterface

// File: rtl/conv_output_writer_row_packer.sv
// Row accumulator: inserts one pixel bit per column and clears on row
// handoff so the next row's first pixel lands without a bubble.
module conv_row_packer
  import conv_output_writer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COL_W  = COL_W_DEF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              clr,
  input  logic              cap,
  input  logic              flush,
  input  logic [COL_W-1:0]  col,
  input  logic              pix_neg,
  output logic [DATA_W-1:0] row_full
);

  logic [DATA_W-1:0] row_acc;

  // row_full already carries this cycle's bit for the handoff
  always_comb begin
    row_full = row_acc;
    if (cap) row_full[col] = pix_neg ? ~POS_BIT : POS_BIT;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      row_acc <= '0;
    end else if (clr || flush) begin
      row_acc <= '0;
    end else if (cap) begin
      row_acc <= row_full;
    end
  end

endmodule

// File: rtl/conv_output_writer.sv
// Writeback stage: packs pixel rows into SRAM words and tracks the pointer.
// Define CONV_OUTPUT_WRITER_HEADER_EN to prepend a row-count header word.
module conv_output_writer
  import conv_output_writer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int COL_W  = COL_W_DEF
) (
  input logic clk,
  input logic reset_b,
  conv_output_writer_if.slave bus
);

`ifdef CONV_OUTPUT_WRITER_HEADER_EN
  localparam logic [ADDR_W-1:0] ROW_OFS = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] ROW_OFS = '0;
`endif

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] row_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] row_full;
  logic              we_q;
  logic              done_q;
  logic              err_q;
  logic              cap;
  logic              flush;
`ifdef CONV_OUTPUT_WRITER_HEADER_EN
  logic [ADDR_W-1:0] base_q;
`endif

  // mat_start wins over a same-cycle pixel
  assign cap   = bus.pix_valid & ~bus.mat_start & (state == ACTIVE);
  assign flush = cap & bus.row_last;

  conv_row_packer #(
    .DATA_W (DATA_W),
    .COL_W  (COL_W)
  ) u_packer (
    .clk      (clk),
    .reset_b  (reset_b),
    .clr      (bus.mat_start),
    .cap      (cap),
    .flush    (flush),
    .col      (bus.pix_col),
    .pix_neg  (bus.pix_neg),
    .row_full (row_full)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      row_cnt <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CONV_OUTPUT_WRITER_HEADER_EN
      base_q  <= '0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (bus.mat_start) begin
        state   <= ACTIVE;
        wr_ptr  <= bus.base_addr + ROW_OFS;
        row_cnt <= '0;
        err_q   <= 1'b0;
`ifdef CONV_OUTPUT_WRITER_HEADER_EN
        base_q  <= bus.base_addr;
`endif
      end else begin
        if (bus.pix_valid && state != ACTIVE) err_q <= 1'b1;
        unique case (state)
          ACTIVE: begin
            if (flush) begin
              we_q    <= 1'b1;
              addr_q  <= wr_ptr;
              data_q  <= row_full;
              wr_ptr  <= wr_ptr + ADDR_W'(1);
              row_cnt <= row_cnt + ADDR_W'(1);
              if (bus.mat_last) begin
`ifdef CONV_OUTPUT_WRITER_HEADER_EN
                state  <= HDR;
`else
                state  <= IDLE;
                done_q <= 1'b1;
`endif
              end
            end
          end
`ifdef CONV_OUTPUT_WRITER_HEADER_EN
          HDR: begin
            we_q   <= 1'b1;
            addr_q <= base_q;
            data_q <= DATA_W'(row_cnt);
            done_q <= 1'b1;
            state  <= IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.dut_sram_write_address = addr_q;
  assign bus.dut_sram_write_data    = data_q;
  assign bus.dut_sram_write_enable  = we_q;
  assign bus.mat_done               = done_q;
  assign bus.busy                   = (state != IDLE) | we_q;
  assign bus.err_overrun            = err_q;

endmodule
